// File: rtl/regfile_pkg.sv
// Shared sizes and source indices for the register-file writeback path.
package regfile_pkg;
  localparam int REG_W = 16;
  localparam int NREG  = 8;
  localparam int ADR_W = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  typedef logic [ADR_W-1:0] adr_t;
  typedef logic [REG_W-1:0] data_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters feeding the issue-stage hazard check.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_inc_en,
  input  adr_t            i_inc_adr,
  input  logic            i_dec_en,
  input  adr_t            i_dec_adr,
  output logic [NREG-1:0] o_busy,
  output logic [1:0]      o_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt     [NREG];
  logic [CNT_W-1:0] w_cnt_nxt [NREG];
  logic [NREG-1:0]  w_inc_hit;
  logic [NREG-1:0]  w_dec_hit;
  logic             w_ovf;
  logic             w_unf;
  logic [1:0]       r_err;

  assign w_inc_hit = i_inc_en ? (NREG'(1) << i_inc_adr) : '0;
  assign w_dec_hit = i_dec_en ? (NREG'(1) << i_dec_adr) : '0;

  // A reservation and a write to the same register cancel, so no limit is hit.
  always_comb begin
    w_ovf = 1'b0;
    w_unf = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (w_inc_hit[r] && !w_dec_hit[r]) begin
        if (r_cnt[r] == CNT_MAX) w_ovf = 1'b1;
        else                     w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      end else if (w_dec_hit[r] && !w_inc_hit[r]) begin
        if (r_cnt[r] == '0) w_unf = 1'b1;
        else                w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_err <= 2'b00;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_nxt[r];
      r_err <= r_err | {w_unf, w_ovf};
    end
  end

  always_comb begin
    o_busy = '0;
    for (int r = 0; r < NREG; r++) o_busy[r] = |r_cnt[r];
  end

  assign o_err = r_err;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with a registered write port and pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NSRC  = 2,
  parameter int CNT_W = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_valid,
  output logic [NSRC-1:0] src_ready,
  input  logic [2:0]      src_adr0,
  input  logic [15:0]     src_data0,
  input  logic [2:0]      src_adr1,
  input  logic [15:0]     src_data1,
  input  logic            rsv_valid,
  input  logic [2:0]      rsv_adr,
  output logic            RegWrite,
  output logic [2:0]      adr_w,
  output logic [15:0]     Din,
  output logic [7:0]      busy,
  output logic [1:0]      err
);
  logic            r_reg_write;
  adr_t            r_adr_w;
  data_t           r_din;
  logic            r_last_grant;
  logic [NSRC-1:0] w_grant;
  logic            w_xfer;
  logic            w_sel;
  adr_t            w_adr;
  data_t           w_data;

  // On a tie the source that did not win last time goes first.
  always_comb begin
    w_grant = '0;
    if (src_valid[SRC_ALU] &&
        (!src_valid[SRC_MEM] || r_last_grant == 1'(SRC_MEM)))
      w_grant[SRC_ALU] = 1'b1;
    else if (src_valid[SRC_MEM])
      w_grant[SRC_MEM] = 1'b1;
  end

  assign src_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_sel     = w_grant[SRC_MEM];
  assign w_adr     = w_sel ? src_adr1  : src_adr0;
  assign w_data    = w_sel ? src_data1 : src_data0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_adr_w      <= '0;
      r_din        <= '0;
      r_last_grant <= 1'(SRC_MEM);
    end else if (w_xfer) begin
      r_reg_write  <= 1'b1;
      r_adr_w      <= w_adr;
      r_din        <= w_data;
      r_last_grant <= w_sel;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  assign RegWrite = r_reg_write;
  assign adr_w    = r_adr_w;
  assign Din      = r_din;

  wb_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_inc_en  (rsv_valid),
    .i_inc_adr (rsv_adr),
    .i_dec_en  (w_xfer),
    .i_dec_adr (w_adr),
    .o_busy    (busy),
    .o_err     (err)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// all checked against a behavioural model of the arbiter and scoreboard.
module tb_regfile_wb_arbiter;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clock;
  logic        reset;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [2:0]  src_adr0;
  logic [15:0] src_data0;
  logic [2:0]  src_adr1;
  logic [15:0] src_data1;
  logic        rsv_valid;
  logic [2:0]  rsv_adr;
  logic        RegWrite;
  logic [2:0]  adr_w;
  logic [15:0] Din;
  logic [7:0]  busy;
  logic [1:0]  err;

  regfile_wb_arbiter #(.NSRC(2), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_adr0  (src_adr0),
    .src_data0 (src_data0),
    .src_adr1  (src_adr1),
    .src_data1 (src_data1),
    .rsv_valid (rsv_valid),
    .rsv_adr   (rsv_adr),
    .RegWrite  (RegWrite),
    .adr_w     (adr_w),
    .Din       (Din),
    .busy      (busy),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_cnt [8];
  logic [1:0]  m_err;
  logic        m_last;
  logic        m_we;
  logic [2:0]  m_adr;
  logic [15:0] m_din;
  logic [1:0]  m_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_ready(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_err  = 2'b00;
    m_last = 1'b1;
    m_we   = 1'b0;
    m_adr  = 3'd0;
    m_din  = 16'd0;
    m_gnt  = 2'b00;
  endtask

  task automatic model_edge();
    logic [1:0] g;
    logic       sel;
    g = model_ready(src_valid, m_last);
    m_gnt = g;
    if (g != 2'b00) begin
      sel    = g[1];
      m_we   = 1'b1;
      m_adr  = sel ? src_adr1  : src_adr0;
      m_din  = sel ? src_data1 : src_data0;
      m_last = sel;
    end else begin
      m_we = 1'b0;
    end
    if (!(rsv_valid && g != 2'b00 && rsv_adr == m_adr)) begin
      if (rsv_valid) begin
        if (m_cnt[rsv_adr] == CNT_MAX) m_err[0] = 1'b1;
        else m_cnt[rsv_adr] = m_cnt[rsv_adr] + 1;
      end
      if (g != 2'b00) begin
        if (m_cnt[m_adr] == 0) m_err[1] = 1'b1;
        else m_cnt[m_adr] = m_cnt[m_adr] - 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    if (reset) model_edge();
  end

  // Inputs change at negedge+1; everything is compared at negedge+2.
  initial forever begin
    @(negedge clock);
    #2;
    if (chk_en) begin
      chk("src_ready", 32'(src_ready), 32'(model_ready(src_valid, m_last)));
      chk("RegWrite",  32'(RegWrite),  32'(m_we));
      chk("adr_w",     32'(adr_w),     32'(m_adr));
      chk("Din",       32'(Din),       32'(m_din));
      chk("busy",      32'(busy),      32'(model_busy()));
      chk("err",       32'(err),       32'(m_err));
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic pin_wait();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
  endtask

  task automatic drive_random();
    if (m_gnt[0] || !src_valid[0]) begin
      src_valid[0] = ($urandom % 4) != 0;
      src_adr0     = 3'($urandom);
      src_data0    = 16'($urandom);
    end
    if (m_gnt[1] || !src_valid[1]) begin
      src_valid[1] = ($urandom % 4) != 0;
      src_adr1     = 3'($urandom);
      src_data1    = 16'($urandom);
    end
    rsv_valid = ($urandom % 3) == 0;
    rsv_adr   = 3'($urandom);
  endtask

  initial begin
    int exp_seq [4];
    exp_seq = '{3, 5, 3, 5};
    reset     = 1'b0;
    model_reset();
    src_valid = 2'b11;
    src_adr0  = 3'd1; src_data0 = 16'hA5A5;
    src_adr1  = 3'd2; src_data1 = 16'h5A5A;
    rsv_valid = 1'b0; rsv_adr   = 3'd0;

    // reset with both sources pending; source 0 wins the first tie
    step(); step();
    chk_en = 1'b1;
    pin_wait();
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    reset = 1'b1;
    pin_wait();
    chk("first_ready", 32'(src_ready), 32'b01);
    step();
    src_valid = 2'b00;
    pin_wait();
    chk("first_we", 32'(RegWrite), 32'd1);
    chk("first_adr", 32'(adr_w), 32'd1);
    chk("first_din", 32'(Din), 32'hA5A5);

    // alternating grants on a sustained tie
    do_reset();
    src_valid = 2'b11;
    src_adr0 = 3'd3; src_data0 = 16'h1111;
    src_adr1 = 3'd5; src_data1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      step();
      pin_wait();
      chk("alt_adr", 32'(adr_w), 32'(exp_seq[k]));
      chk("alt_din", 32'(Din), (exp_seq[k] == 3) ? 32'h1111 : 32'h2222);
    end
    src_valid = 2'b00;

    // two reservations of r2 retired by two loads
    do_reset();
    rsv_valid = 1'b1; rsv_adr = 3'd2;
    step(); step();
    rsv_valid = 1'b0;
    src_valid = 2'b10; src_adr1 = 3'd2; src_data1 = 16'hBEEF;
    pin_wait();
    chk("rsv2_busy_a", 32'(busy[2]), 32'd1);
    step();
    src_data1 = 16'hCAFE;
    pin_wait();
    chk("rsv2_busy_b", 32'(busy[2]), 32'd1);
    chk("rsv2_din_b", 32'(Din), 32'hBEEF);
    step();
    src_valid = 2'b00;
    pin_wait();
    chk("rsv2_busy_c", 32'(busy[2]), 32'd0);
    chk("rsv2_err", 32'(err), 32'd0);
    chk("rsv2_din_c", 32'(Din), 32'hCAFE);

    // simultaneous reserve and write of r4
    do_reset();
    rsv_valid = 1'b1; rsv_adr = 3'd4;
    step();
    src_valid = 2'b01; src_adr0 = 3'd4; src_data0 = 16'h4444;
    step();
    rsv_valid = 1'b0; src_valid = 2'b00;
    pin_wait();
    chk("same_busy4", 32'(busy[4]), 32'd1);
    chk("same_err", 32'(err), 32'd0);
    chk("same_we", 32'(RegWrite), 32'd1);

    // overflow on r7, underflow on r6
    do_reset();
    rsv_valid = 1'b1; rsv_adr = 3'd7;
    repeat (4) step();
    rsv_valid = 1'b0;
    pin_wait();
    chk("ovf_busy7", 32'(busy[7]), 32'd1);
    chk("ovf_err", 32'(err), 32'b01);
    step();
    src_valid = 2'b01; src_adr0 = 3'd6; src_data0 = 16'h6666;
    step();
    src_valid = 2'b00;
    pin_wait();
    chk("unf_err", 32'(err), 32'b11);
    chk("unf_adr", 32'(adr_w), 32'd6);
    chk("unf_din", 32'(Din), 32'h6666);

    // reset while a load is pending and r1 is reserved
    do_reset();
    rsv_valid = 1'b1; rsv_adr = 3'd1;
    step();
    rsv_valid = 1'b0;
    src_valid = 2'b10; src_adr1 = 3'd0; src_data1 = 16'h0123;
    reset = 1'b0;
    model_reset();
    pin_wait();
    chk("mid_we", 32'(RegWrite), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    step();
    reset = 1'b1;
    pin_wait();
    chk("mid_ready", 32'(src_ready), 32'b10);
    step();
    src_valid = 2'b00;
    pin_wait();
    chk("mid_we2", 32'(RegWrite), 32'd1);
    chk("mid_din", 32'(Din), 32'h0123);
    chk("mid_err2", 32'(err), 32'b10);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (($urandom % 200) == 0) do_reset();
      drive_random();
    end
    src_valid = 2'b00; rsv_valid = 1'b0;
    step(); step();
    pin_wait();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x16 register file between two writeback sources: source 0 = ALU result, source 1 = memory load data.
- Sources use a valid/ready handshake. The block picks one source per cycle by round-robin and drives the file's write-enable, address and data from registers.
- It also keeps a per-register pending-write scoreboard, so the issue stage can stall on read-after-write hazards.

Parameters:
- NSRC, 2, number of writeback sources; fixed at 2 in this revision.
- CNT_W, 2, width of each register's pending-write counter; saturates at 2^CNT_W-1.

Ports:
- clock  input  1  system clock; the block updates on posedge.
- reset  input  1  reset reset, asynchronous, active-low.
- src_valid  input  2  bit i: source i holds a write request.
- src_ready  output  2  bit i: source i is granted this cycle (combinational).
- src_adr0  input  3  destination register, source 0.
- src_data0  input  16  write data, source 0.
- src_adr1  input  3  destination register, source 1.
- src_data1  input  16  write data, source 1.
- rsv_valid  input  1  issue stage reserves one pending write.
- rsv_adr  input  3  register being reserved.
- RegWrite  output  1  write enable to the register file.
- adr_w  output  3  write address to the register file.
- Din  output  16  write data to the register file.
- busy  output  8  bit r is 1 when register r has one or more pending writes.
- err  output  2  sticky error flags: bit0 = counter overflow, bit1 = counter underflow.

Behaviour:
- Reset (async, reset=0):
  - RegWrite=0, adr_w=0, Din=0.
  - All pending counters = 0, so busy=0.
  - err=0; last_grant=1, so source 0 wins the first tie.
  - A handshake or reservation in flight when reset asserts is dropped; no write is issued for it.
- Arbitration (combinational):
  - Only one valid source: it is granted.
  - Both valid: the source other than last_grant is granted.
  - None valid: no grant.
  - src_ready is one-hot or zero and never depends on src_ready.
- Handshake:
  - A transfer completes at a posedge where src_valid[i]=1 and src_ready[i]=1.
  - A source keeps valid, adr and data stable until it is granted. The arbiter does not check this.
- Write port timing:
  - On a transfer at posedge N: RegWrite<=1, adr_w<=granted adr, Din<=granted data, last_grant<=i.
  - The register file samples on the following negedge, so the write is visible to reads from cycle N+1.
  - With no transfer: RegWrite<=0; adr_w and Din hold their values.
  - Throughput is one write per cycle; latency is 1 posedge plus half a cycle.
- Scoreboard (posedge, one counter per register):
  - rsv_valid increments cnt[rsv_adr].
  - A write transfer decrements cnt[granted adr].
  - Increment and decrement on the same register in the same cycle: the count is unchanged, and no error is flagged even at a limit.
  - Increment at the maximum value: the count holds and err[0]<=1.
  - Decrement at 0: the count holds at 0 and err[1]<=1. The write is still performed.
  - busy[r] = (cnt[r]!=0), decoded from registers.
- Register r0 is not special-cased; it is written like any other register.
- err bits clear only on reset.

Decomposition:
- Shared package (regfile_pkg):
  - REG_W=16, NREG=8, ADR_W=3.
  - Source index constants SRC_ALU=0 and SRC_MEM=1.
- Sub-module wb_scoreboard: NREG x CNT_W counters with inc/dec ports, busy vector and error flags.
- The arbiter and write-port registers live in the top module.

Test Plan:
- Reset with both sources valid, then release reset → src_ready=01 in the first cycle. Next posedge: RegWrite=1, adr_w=src_adr0, Din=src_data0. Next negedge: the register file holds that value.
- Both sources valid for 4 cycles, src_adr0=3/data 0x1111, src_adr1=5/data 0x2222 → grants alternate 0,1,0,1; the written sequence is r3,r5,r3,r5.
- rsv_valid for r2 twice, then two writes from source 1 → busy[2]=1 until the second transfer's posedge, then 0. err=00 throughout.
- In the same cycle, rsv_adr=4 with rsv_valid and a source 0 write to r4 while cnt[4]=1 → cnt[4] stays 1, busy[4] stays 1, err=00.
- Four reservations of r7 with CNT_W=2 → cnt[7]=3 and err[0]=1. A write to r6 with cnt[6]=0 → err[1]=1 and r6 is still written.
- Assert reset while source 1 is valid and one register is reserved → RegWrite=0, busy=0, err=0 immediately. After release, source 1 is granted on the first cycle.
